gpio_ctrl: RTL and testbench
============================

// Module: gpio_ctrl
// PURPOSE
//   Memory-mapped controller for one 8-pin GPIO port. Holds direction/output registers that drive the
//   tri-state pin block (GPIO_PORT), synchronises pin readback, detects per-pin edges and raises a
//   level interrupt. Sits between the VeSPA peripheral bus and the GPIO pin block.
// PARAMETERS
//   WIDTH        8   number of GPIO pins
//   SYNC_STAGES  2   flops in the input synchroniser (>=2)
//   ADDR_W       3   register address width
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   rst        in   1        synchronous, active-high reset
//   bus_addr   in   ADDR_W   register select
//   bus_wr     in   1        write strobe, one-cycle
//   bus_rd     in   1        read strobe, one-cycle
//   bus_wdata  in   WIDTH    write data
//   bus_rdata  out  WIDTH    read data, valid when bus_rvalid
//   bus_rvalid out  1        read data valid pulse
//   gpio_dir   out  WIDTH    to pin block: 1 = drive pin, 0 = Hi-Z
//   gpio_out   out  WIDTH    to pin block: value driven on output pins
//   gpio_in    in   WIDTH    from pin block: raw (asynchronous) pin levels
//   irq        out  1        registered interrupt, level, active-high
// BEHAVIOUR
//   Register map (addr: name, access, reset):
//     0 DIR rw 0x00 | 1 OUT rw 0x00 | 2 IN ro (synced pins) | 3 IRQ_EN rw 0x00
//     4 EDGE rw 0x00 (per bit 1=rising, 0=falling) | 5 STAT w1c 0x00
//     6 OUT_SET wo (OUT |= wdata) | 7 OUT_CLR wo (OUT &= ~wdata)
//   - Writes take effect on the clock edge where bus_wr=1; gpio_dir/gpio_out are the DIR/OUT flops directly.
//   - Writes to IN ignored. Reads of 6/7 return 0. bus_wr and bus_rd together: write performed, read
//     returns the pre-write value.
//   - Read latency 1: bus_rd at cycle N -> bus_rdata/bus_rvalid at N+1; rvalid is a single-cycle pulse;
//     bus_rdata holds last value otherwise.
//   - Synchroniser: gpio_in passes SYNC_STAGES flops -> sync; IN reflects a pin change SYNC_STAGES cycles later.
//   - Edge detect: prev <= sync every cycle; rise = sync & ~prev; fall = ~sync & prev;
//     hit[i] = EDGE[i] ? rise[i] : fall[i]. STAT[i] set on hit[i] regardless of IRQ_EN.
//   - STAT clear: write 5 with bit=1 clears that bit; set-on-hit wins over same-cycle clear.
//   - irq <= |(STAT & IRQ_EN); pin edge -> STAT set at SYNC_STAGES+1 cycles -> irq at SYNC_STAGES+2.
//     Enabling IRQ_EN over an already-set STAT raises irq the cycle after the write.
//   - Edges on output pins (DIR=1) are detected normally (pin readback includes driven value).
//   - Post-reset priming: edge detection disabled for SYNC_STAGES+1 cycles after rst deasserts (small
//     counter), so pins already high at reset never produce spurious STAT bits.
//   - Reset (any cycle, incl. mid-read): all registers, sync flops, prev, STAT, irq, bus_rvalid,
//     bus_rdata -> 0; an in-flight read yields no rvalid.
// STRUCTURE
//   - gpio_pkg: register address localparams (GPIO_DIR..GPIO_OUT_CLR), reset values.
//   - Sub-module gpio_sync: WIDTH-wide SYNC_STAGES-deep synchroniser with synchronous reset.
//   - Top: register file + decode, edge detect/STAT, priming counter, read mux; instantiated next to GPIO_PORT.
// TESTING
//   1 Reset: assert rst with gpio_in=0xFF, release -> all outputs 0, STAT stays 0x00 for 20 cycles.
//   2 Write DIR=0xF0, OUT=0xA5, OUT_SET 0x0A, OUT_CLR 0x20 -> gpio_dir=0xF0, gpio_out=0x8F; read 1 = 0x8F, rvalid 1 cycle after rd.
//   3 IRQ_EN=0x01, EDGE=0x01, gpio_in[0] 0->1 at cycle T -> IN bit0 at T+2, STAT=0x01 at T+3, irq=1 at T+4.
//   4 EDGE[3]=0, gpio_in[3] 1->0 with IRQ_EN=0 -> STAT=0x08, irq=0; write IRQ_EN=0x08 -> irq=1 next cycle.
//   5 W1C 0x08 in same cycle as new falling hit on pin 3 -> STAT bit3 stays 1; later W1C 0x08 -> irq drops next cycle.
//   6 bus_rd on addr 2 and rst in the following cycle -> no rvalid, bus_rdata=0x00.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register map and reset values for the GPIO port controller.
package gpio_pkg;

    localparam int unsigned GPIO_DIR     = 0;
    localparam int unsigned GPIO_OUT     = 1;
    localparam int unsigned GPIO_IN      = 2;
    localparam int unsigned GPIO_IRQ_EN  = 3;
    localparam int unsigned GPIO_EDGE    = 4;
    localparam int unsigned GPIO_STAT    = 5;
    localparam int unsigned GPIO_OUT_SET = 6;
    localparam int unsigned GPIO_OUT_CLR = 7;

    localparam int unsigned GPIO_RST_DIR    = 0;
    localparam int unsigned GPIO_RST_OUT    = 0;
    localparam int unsigned GPIO_RST_IRQ_EN = 0;
    localparam int unsigned GPIO_RST_EDGE   = 0;
    localparam int unsigned GPIO_RST_STAT   = 0;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage pin synchroniser; every lane is an independent
// SYNC_STAGES-deep shift chain cleared by the synchronous reset.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Bus-mapped controller for one GPIO port: DIR/OUT registers, synced
// readback, per-pin edge capture into STAT and a registered level irq.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_wr,
    input  logic              bus_rd,
    input  logic [WIDTH-1:0]  bus_wdata,
    output logic [WIDTH-1:0]  bus_rdata,
    output logic              bus_rvalid,
    output logic [WIDTH-1:0]  gpio_dir,
    output logic [WIDTH-1:0]  gpio_out,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic              irq
);

    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_N = PW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_stat;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;
    logic             r_irq;
    logic [PW-1:0]    r_prime;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_hit;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rmux;
    logic             w_armed;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (gpio_in),
        .o_q (w_sync)
    );

    // Edge detection stays off until the sync chain and prev hold real pin levels.
    assign w_armed = (r_prime == PRIME_N);
    assign w_rise  = w_sync & ~r_prev;
    assign w_fall  = ~w_sync & r_prev;
    assign w_hit   = w_armed ? ((r_edge & w_rise) | (~r_edge & w_fall)) : '0;
    assign w_clr   = (bus_wr && bus_addr == ADDR_W'(GPIO_STAT)) ? bus_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir    <= WIDTH'(GPIO_RST_DIR);
            r_out    <= WIDTH'(GPIO_RST_OUT);
            r_irq_en <= WIDTH'(GPIO_RST_IRQ_EN);
            r_edge   <= WIDTH'(GPIO_RST_EDGE);
        end else if (bus_wr) begin
            case (bus_addr)
                ADDR_W'(GPIO_DIR):     r_dir    <= bus_wdata;
                ADDR_W'(GPIO_OUT):     r_out    <= bus_wdata;
                ADDR_W'(GPIO_IRQ_EN):  r_irq_en <= bus_wdata;
                ADDR_W'(GPIO_EDGE):    r_edge   <= bus_wdata;
                ADDR_W'(GPIO_OUT_SET): r_out    <= r_out | bus_wdata;
                ADDR_W'(GPIO_OUT_CLR): r_out    <= r_out & ~bus_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= '0;
            r_stat  <= WIDTH'(GPIO_RST_STAT);
            r_irq   <= 1'b0;
            r_prime <= '0;
        end else begin
            r_prev <= w_sync;
            // A fresh hit beats a clear landing in the same cycle.
            r_stat <= (r_stat & ~w_clr) | w_hit;
            r_irq  <= |(r_stat & r_irq_en);
            if (!w_armed) begin
                r_prime <= r_prime + 1'b1;
            end
        end
    end

    always_comb begin
        w_rmux = '0;
        case (bus_addr)
            ADDR_W'(GPIO_DIR):    w_rmux = r_dir;
            ADDR_W'(GPIO_OUT):    w_rmux = r_out;
            ADDR_W'(GPIO_IN):     w_rmux = w_sync;
            ADDR_W'(GPIO_IRQ_EN): w_rmux = r_irq_en;
            ADDR_W'(GPIO_EDGE):   w_rmux = r_edge;
            ADDR_W'(GPIO_STAT):   w_rmux = r_stat;
            default:              w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= bus_rd;
            if (bus_rd) begin
                r_rdata <= w_rmux;
            end
        end
    end

    assign bus_rdata  = r_rdata;
    assign bus_rvalid = r_rvalid;
    assign gpio_dir   = r_dir;
    assign gpio_out   = r_out;
    assign irq        = r_irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: register table, read scoreboard and
// hand-timed edge/irq/reset sequences.
module tb_gpio_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] bus_addr;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_rvalid;
    logic [7:0] gpio_dir;
    logic [7:0] gpio_out;
    logic [7:0] gpio_in;
    logic       irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];

    typedef struct {
        logic       wr;
        logic       rd;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic [7:0] exp_dir;
        logic [7:0] exp_out;
    } vec_t;

    vec_t tbl[11];

    gpio_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus_addr   (bus_addr),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .gpio_dir   (gpio_dir),
        .gpio_out   (gpio_out),
        .gpio_in    (gpio_in),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    // One bus cycle; read results are pushed/popped through the scoreboard.
    task automatic step(input string tag, input logic wr, input logic rd,
                        input logic [2:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rd);
        logic [7:0] e;
        logic       ev;
        bus_wr    = wr;
        bus_rd    = rd;
        bus_addr  = addr;
        bus_wdata = wdata;
        if (rd) sb.push_back(exp_rd);
        @(posedge clk);
        #1;
        bus_wr = 1'b0;
        bus_rd = 1'b0;
        ev = (sb.size() != 0);
        chk({tag, " rvalid"}, {7'd0, bus_rvalid}, {7'd0, ev});
        if (ev) begin
            e = sb.pop_front();
            if (bus_rvalid) chk({tag, " rdata"}, bus_rdata, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'hF0, 8'h00, 8'hF0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 3'd1, 8'hA5, 8'h00, 8'hF0, 8'hA5};
        tbl[2]  = '{1'b1, 1'b0, 3'd6, 8'h0A, 8'h00, 8'hF0, 8'hAF};
        tbl[3]  = '{1'b1, 1'b0, 3'd7, 8'h20, 8'h00, 8'hF0, 8'h8F};
        tbl[4]  = '{1'b0, 1'b1, 3'd1, 8'h00, 8'h8F, 8'hF0, 8'h8F};
        tbl[5]  = '{1'b0, 1'b1, 3'd0, 8'h00, 8'hF0, 8'hF0, 8'h8F};
        tbl[6]  = '{1'b0, 1'b1, 3'd6, 8'h00, 8'h00, 8'hF0, 8'h8F};
        tbl[7]  = '{1'b1, 1'b1, 3'd2, 8'h00, 8'hFF, 8'hF0, 8'h8F};
        tbl[8]  = '{1'b1, 1'b1, 3'd1, 8'h11, 8'h8F, 8'hF0, 8'h11};
        tbl[9]  = '{1'b1, 1'b1, 3'd7, 8'h01, 8'h00, 8'hF0, 8'h10};
        tbl[10] = '{1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 8'hF0, 8'h10};

        rst       = 1'b1;
        bus_addr  = 3'd0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_wdata = 8'h00;
        gpio_in   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state with pins high
        chk("rst dir", gpio_dir, 8'h00);
        chk("rst out", gpio_out, 8'h00);
        chk("rst irq", {7'd0, irq}, 8'h00);
        chk("rst rvalid", {7'd0, bus_rvalid}, 8'h00);
        chk("rst rdata", bus_rdata, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step("prime stat", 1'b0, 1'b1, 3'd5, 8'h00, 8'h00);
            chk("prime irq", {7'd0, irq}, 8'h00);
        end
        step("rst in", 1'b0, 1'b1, 3'd2, 8'h00, 8'hFF);

        // register table
        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr,
                 tbl[i].wdata, tbl[i].exp_rd);
            chk($sformatf("vec%0d dir", i), gpio_dir, tbl[i].exp_dir);
            chk($sformatf("vec%0d out", i), gpio_out, tbl[i].exp_out);
        end

        // default falling-edge capture on all pins, then w1c
        gpio_in = 8'h00;
        idle(5);
        step("fall stat", 1'b0, 1'b1, 3'd5, 8'h00, 8'hFF);
        chk("fall irq", {7'd0, irq}, 8'h00);
        step("w1c all", 1'b1, 1'b0, 3'd5, 8'hFF, 8'h00);
        step("stat clr", 1'b0, 1'b1, 3'd5, 8'h00, 8'h00);

        // rising edge on pin 0: IN, STAT and irq latency
        step("en0", 1'b1, 1'b0, 3'd3, 8'h01, 8'h00);
        step("edge0", 1'b1, 1'b0, 3'd4, 8'h01, 8'h00);
        idle(2);
        gpio_in = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("in k%0d", k), 1'b0, 1'b1, 3'd2, 8'h00,
                 (k >= 3) ? 8'h01 : 8'h00);
            chk($sformatf("irq k%0d", k), {7'd0, irq}, (k == 4) ? 8'h01 : 8'h00);
        end
        step("stat0", 1'b0, 1'b1, 3'd5, 8'h00, 8'h01);
        step("w1c0", 1'b1, 1'b0, 3'd5, 8'h01, 8'h00);
        chk("w1c0 irq hold", {7'd0, irq}, 8'h01);
        idle(1);
        chk("w1c0 irq drop", {7'd0, irq}, 8'h00);
        step("dis", 1'b1, 1'b0, 3'd3, 8'h00, 8'h00);

        // falling pin 3 while masked, then unmask
        gpio_in = 8'h09;
        idle(5);
        step("rise3 stat", 1'b0, 1'b1, 3'd5, 8'h00, 8'h00);
        gpio_in = 8'h01;
        idle(5);
        step("fall3 stat", 1'b0, 1'b1, 3'd5, 8'h00, 8'h08);
        chk("masked irq", {7'd0, irq}, 8'h00);
        step("en3", 1'b1, 1'b0, 3'd3, 8'h08, 8'h00);
        chk("en3 irq same", {7'd0, irq}, 8'h00);
        idle(1);
        chk("en3 irq next", {7'd0, irq}, 8'h01);

        // clear colliding with a new hit on pin 3
        gpio_in = 8'h09;
        idle(5);
        gpio_in = 8'h01;
        idle(2);
        step("w1c race", 1'b1, 1'b0, 3'd5, 8'h08, 8'h00);
        step("race stat", 1'b0, 1'b1, 3'd5, 8'h00, 8'h08);
        chk("race irq", {7'd0, irq}, 8'h01);
        step("w1c3", 1'b1, 1'b0, 3'd5, 8'h08, 8'h00);
        chk("w1c3 irq hold", {7'd0, irq}, 8'h01);
        idle(1);
        chk("w1c3 irq drop", {7'd0, irq}, 8'h00);
        step("stat3 clr", 1'b0, 1'b1, 3'd5, 8'h00, 8'h00);

        // read aborted by reset
        step("pre rd", 1'b0, 1'b1, 3'd2, 8'h00, 8'h01);
        bus_rd   = 1'b1;
        bus_addr = 3'd2;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        bus_rd = 1'b0;
        chk("abort rvalid", {7'd0, bus_rvalid}, 8'h00);
        chk("abort rdata", bus_rdata, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort rvalid2", {7'd0, bus_rvalid}, 8'h00);
        chk("post dir", gpio_dir, 8'h00);
        chk("post out", gpio_out, 8'h00);
        chk("post irq", {7'd0, irq}, 8'h00);
        idle(2);
        step("post rd dir", 1'b0, 1'b1, 3'd0, 8'h00, 8'h00);
        step("post rd edge", 1'b0, 1'b1, 3'd4, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
